// File: rtl/sopc_onchip_ram_pipelined_pkg.sv
// Shared types and constants for the pipelined on-chip RAM slave.
// Imported by the top level and the RAM core.
package sopc_ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } ram_state_t;

  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 3;

  function automatic int lanes(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/sopc_onchip_ram_pipelined_core.sv
// Single-port byte-enable RAM with a registered read port.
// The caller guarantees that the address is below DEPTH whenever we or re is high.
module sopc_ram_core
  import sopc_ram_pkg::*;
#(
  parameter int    DATA_W    = 32,
  parameter int    DEPTH     = 2560,
  parameter int    IDX_W     = 12,
  parameter string INIT_FILE = ""
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [lanes(DATA_W)-1:0]  be,
  input  logic [IDX_W-1:0]          addr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic                      re,
  output logic [DATA_W-1:0]         rdata
);

  localparam int LANES = lanes(DATA_W);

  logic [LANES-1:0][7:0] mem_q [DEPTH];
  logic [DATA_W-1:0]     rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) mem_q[addr][i] <= wdata[8*i +: 8];
      end
    end
    if (re) rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sopc_onchip_ram_pipelined.sv
// Avalon-MM on-chip RAM slave: zero-fill sequencer after reset, byte-enable writes,
// and a fixed-latency read pipeline that drains even while command acceptance is stalled.
module sopc_onchip_ram_pipelined
  import sopc_ram_pkg::*;
#(
  parameter int    DATA_W         = 32,
  parameter int    DEPTH          = 2560,
  parameter int    ADDR_W         = 12,
  parameter int    READ_LATENCY   = 2,
  parameter int    CLEAR_ON_RESET = 1,
  parameter string INIT_FILE      = ""
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      reset_req,
  input  logic                      clken,
  input  logic                      chipselect,
  input  logic                      read,
  input  logic                      write,
  input  logic [ADDR_W-1:0]         address,
  input  logic [lanes(DATA_W)-1:0]  byteenable,
  input  logic [DATA_W-1:0]         writedata,
  output logic [DATA_W-1:0]         readdata,
  output logic                      readdatavalid,
  output logic                      waitrequest,
  output logic                      init_done
);

  localparam int LANES = lanes(DATA_W);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (READ_LATENCY < READ_LATENCY_MIN || READ_LATENCY > READ_LATENCY_MAX) begin : g_bad_latency
    $error("READ_LATENCY must be within 1..3");
  end

  ram_state_t               state_q, state_d;
  logic [IDX_W-1:0]         clear_addr_q, clear_addr_d;
  logic [READ_LATENCY-1:0]  vld_q, vld_d;
  logic [READ_LATENCY-1:0]  zero_q, zero_d;

  logic run, in_range, accept, bus_wr, bus_rd, clear_wr;
  logic                 core_we, core_re;
  logic [LANES-1:0]     core_be;
  logic [IDX_W-1:0]     core_addr;
  logic [DATA_W-1:0]    core_wdata, core_rdata;
  logic [DATA_W-1:0]    stage_data [READ_LATENCY];

  assign run      = clken & ~reset_req;
  assign in_range = {1'b0, address} < (ADDR_W+1)'(DEPTH);
  assign accept   = (state_q == ST_READY) & chipselect & (read | write) & run;
  assign bus_wr   = accept & write & in_range;
  // A simultaneous read+write is a write only, so it never enters the read pipeline.
  assign bus_rd   = accept & read & ~write;
  assign clear_wr = (state_q == ST_CLEAR) & run & (CLEAR_ON_RESET != 0);

  assign core_we    = clear_wr | bus_wr;
  assign core_re    = bus_rd & in_range;
  assign core_addr  = clear_wr ? clear_addr_q : address[IDX_W-1:0];
  assign core_be    = clear_wr ? {LANES{1'b1}} : byteenable;
  assign core_wdata = clear_wr ? '0 : writedata;

  always_comb begin
    state_d      = state_q;
    clear_addr_d = clear_addr_q;
    if (state_q == ST_CLEAR) begin
      if (CLEAR_ON_RESET == 0) begin
        state_d = ST_READY;
      end else if (run) begin
        if (clear_addr_q == IDX_W'(DEPTH - 1)) begin
          state_d      = ST_READY;
          clear_addr_d = '0;
        end else begin
          clear_addr_d = clear_addr_q + 1'b1;
        end
      end
    end
  end

  // The zero flag travels with each read so out-of-range reads return zero on time.
  always_comb begin
    vld_d[0]  = bus_rd;
    zero_d[0] = ~in_range;
    for (int i = 1; i < READ_LATENCY; i++) begin
      vld_d[i]  = vld_q[i-1];
      zero_d[i] = zero_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_CLEAR;
      clear_addr_q <= '0;
      vld_q        <= '0;
      zero_q       <= '0;
    end else begin
      state_q      <= state_d;
      clear_addr_q <= clear_addr_d;
      vld_q        <= vld_d;
      zero_q       <= zero_d;
    end
  end

  sopc_ram_core #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .IDX_W     (IDX_W),
    .INIT_FILE (INIT_FILE)
  ) u_core (
    .clk   (clk),
    .we    (core_we),
    .be    (core_be),
    .addr  (core_addr),
    .wdata (core_wdata),
    .re    (core_re),
    .rdata (core_rdata)
  );

  assign stage_data[0] = core_rdata;

  for (genvar gi = 1; gi < READ_LATENCY; gi++) begin : g_hold
    logic [DATA_W-1:0] hold_q, hold_d;
    always_comb hold_d = stage_data[gi-1];
    always_ff @(posedge clk) hold_q <= hold_d;
    assign stage_data[gi] = hold_q;
  end

  assign readdatavalid = vld_q[READ_LATENCY-1];
  assign readdata      = (vld_q[READ_LATENCY-1] & ~zero_q[READ_LATENCY-1]) ?
                         stage_data[READ_LATENCY-1] : '0;
  assign waitrequest   = (state_q == ST_READY) ? ~run : 1'b1;
  assign init_done     = (state_q == ST_READY);

endmodule
